// File: rtl/hangman_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hangman_pkg
//  Description : Shared types for the multi-player hangman controller:
//                controller state enum, result codes and width helpers.
//  Revision    : 1.0  initial multi-player release
// ============================================================================
package hangman_pkg;

    typedef enum logic [3:0] {
        S_LOAD    = 4'd0,
        S_LOAD_W  = 4'd1,
        S_ARM     = 4'd2,
        S_GRAPH   = 4'd3,
        S_GUESS   = 4'd4,
        S_FILL    = 4'd5,
        S_DRAW    = 4'd6,
        S_NEXT    = 4'd7,
        S_WIN     = 4'd8,
        S_LOSE    = 4'd9,
        S_TIMEOUT = 4'd10
    } state_t;

    localparam logic [1:0] RES_PLAY    = 2'd0;
    localparam logic [1:0] RES_WIN     = 2'd1;
    localparam logic [1:0] RES_LOSE    = 2'd2;
    localparam logic [1:0] RES_TIMEOUT = 2'd3;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hangman_ctrl_mp_turn_timer.sv
`default_nettype none
// ============================================================================
//  Module      : turn_timer
//  Description : Per-turn guess timer. Counts enabled cycles from a clear and
//                flags the last allowed cycle of the turn.
//  Ports       : clk, resetn     - clock, async active-low reset
//                clear           - zero the count (wins over enable)
//                enable          - count this cycle
//                expired         - count has reached TIMEOUT_CYC-1
//  Revision    : 1.0  initial release
// ============================================================================
module turn_timer
    import hangman_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = clog2_min1(TIMEOUT_CYC);
    localparam logic [TW-1:0] c_last = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != c_last)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The cycle holding c_last is the TIMEOUT_CYC-th cycle of the turn.
    assign expired = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/hangman_ctrl_mp.sv
`default_nettype none
// ============================================================================
//  Module      : hangman_ctrl_mp
//  Description : Multi-player hangman control FSM. Sequences word entry,
//                graphic load, guessing turns, fill/draw handshakes and game
//                end; tracks per-player misses and scores, turn order,
//                revealed-letter count and a per-turn timeout.
//  Ports       : clk, resetn                       - clock, async reset (low)
//                load,endinput,start,try,wipe      - key levels
//                graph_loaded,fill_done,draw_done  - datapath done strobes
//                match, hit_cnt                    - guess outcome (with try)
//                ld,ld_g,compare,fill,draw,timecount,over - datapath enables
//                char_idx, player, part, score, result    - status
//  Revision    : 1.0  initial multi-player release
// ============================================================================
module hangman_ctrl_mp
    import hangman_pkg::*;
#(
    parameter int WORD_MAX    = 8,
    parameter int MAX_MISS    = 6,
    parameter int N_PLAYERS   = 2,
    parameter int TIMEOUT_CYC = 1000,
    parameter int TO_IS_MISS  = 0,
    localparam int CW = $clog2(WORD_MAX + 1),
    localparam int MW = $clog2(MAX_MISS + 1),
    localparam int PW = clog2_min1(N_PLAYERS)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load,
    input  logic                   endinput,
    input  logic                   start,
    input  logic                   try,
    input  logic                   wipe,
    input  logic                   graph_loaded,
    input  logic                   fill_done,
    input  logic                   draw_done,
    input  logic                   match,
    input  logic [CW-1:0]          hit_cnt,
    output logic                   ld,
    output logic                   ld_g,
    output logic                   compare,
    output logic                   fill,
    output logic                   draw,
    output logic                   timecount,
    output logic                   over,
    output logic [CW-1:0]          char_idx,
    output logic [PW-1:0]          player,
    output logic [MW-1:0]          part,
    output logic [N_PLAYERS*8-1:0] score,
    output logic [1:0]             result
);

    localparam int SW = ((CW > 8) ? CW : 8) + 1;
    localparam logic [CW-1:0] c_word_max = CW'(WORD_MAX);
    localparam logic [MW-1:0] c_max_miss = MW'(MAX_MISS);

    state_t               r_state;
    logic [CW-1:0]        r_char_idx;
    logic [CW-1:0]        r_revealed;
    logic [PW-1:0]        r_player;
    logic [1:0]           r_result;
    logic [MW-1:0]        r_miss  [N_PLAYERS];
    logic [7:0]           r_score [N_PLAYERS];

    logic                 w_expired;
    logic                 w_take_miss;
    logic [N_PLAYERS-1:0] w_alive;
    logic [PW-1:0]        w_next_player;
    int                   w_dist;
    int                   w_best_dist;
    logic [CW:0]          w_rev_sum;
    logic [CW-1:0]        w_rev_sat;
    logic [SW-1:0]        w_score_sum;
    logic [7:0]           w_score_sat;

    turn_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_turn_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (r_state != S_GUESS),
        .enable  (r_state == S_GUESS),
        .expired (w_expired)
    );

    // Saturating accumulations for a hit.
    assign w_rev_sum   = {1'b0, r_revealed} + {1'b0, hit_cnt};
    assign w_rev_sat   = (w_rev_sum > {1'b0, r_char_idx}) ? r_char_idx : w_rev_sum[CW-1:0];
    assign w_score_sum = SW'(r_score[r_player]) + SW'(hit_cnt);
    assign w_score_sat = (w_score_sum > SW'(255)) ? 8'hFF : w_score_sum[7:0];

    // A timeout with TO_IS_MISS set is handled exactly like a wrong guess.
    assign w_take_miss = (try && !match) ||
                         (!try && w_expired && (TO_IS_MISS != 0));

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
        assign w_alive[p]          = (r_miss[p] < c_max_miss);
        assign score[8*p +: 8]     = r_score[p];
    end

    // Next live player after the current one, wrapping; the current player is
    // the last resort (distance N_PLAYERS).
    always_comb begin
        w_next_player = r_player;
        w_best_dist   = N_PLAYERS + 1;
        w_dist        = 0;
        for (int j = 0; j < N_PLAYERS; j++) begin
            w_dist = (j > int'(r_player)) ? (j - int'(r_player))
                                          : (j + N_PLAYERS - int'(r_player));
            if (w_alive[j] && (w_dist < w_best_dist)) begin
                w_best_dist   = w_dist;
                w_next_player = PW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_LOAD;
            r_char_idx <= '0;
            r_revealed <= '0;
            r_player   <= '0;
            r_result   <= RES_PLAY;
            for (int p = 0; p < N_PLAYERS; p++) begin
                r_miss[p]  <= '0;
                r_score[p] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (load && (r_char_idx < c_word_max)) begin
                        r_char_idx <= r_char_idx + 1'b1;
                        r_state    <= S_LOAD_W;
                    end else if (endinput && (r_char_idx != '0)) begin
                        r_state <= S_ARM;
                    end
                end
                S_LOAD_W: if (!load)        r_state <= S_LOAD;
                S_ARM:    if (start)        r_state <= S_GRAPH;
                S_GRAPH:  if (graph_loaded) r_state <= S_GUESS;
                S_GUESS: begin
                    if (try && match) begin
                        r_revealed        <= w_rev_sat;
                        r_score[r_player] <= w_score_sat;
                        r_state           <= S_FILL;
                    end else if (w_take_miss) begin
                        if (r_miss[r_player] != c_max_miss) begin
                            r_miss[r_player] <= r_miss[r_player] + 1'b1;
                        end
                        r_state <= S_DRAW;
                    end else if (w_expired) begin
                        r_result <= RES_TIMEOUT;
                        r_state  <= S_TIMEOUT;
                    end
                end
                S_FILL: begin
                    if (fill_done) begin
                        if (r_revealed == r_char_idx) begin
                            r_result <= RES_WIN;
                            r_state  <= S_WIN;
                        end else begin
                            r_state <= S_GUESS;
                        end
                    end
                end
                S_DRAW: begin
                    if (draw_done) begin
                        if (w_alive == '0) begin
                            r_result <= RES_LOSE;
                            r_state  <= S_LOSE;
                        end else begin
                            r_state <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    r_player <= w_next_player;
                    r_state  <= S_GUESS;
                end
                S_WIN, S_LOSE, S_TIMEOUT: begin
                    // Scores survive a wipe; only reset clears them.
                    if (wipe) begin
                        r_char_idx <= '0;
                        r_revealed <= '0;
                        r_player   <= '0;
                        r_result   <= RES_PLAY;
                        for (int p = 0; p < N_PLAYERS; p++) begin
                            r_miss[p] <= '0;
                        end
                        r_state <= S_LOAD;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign ld        = (r_state == S_LOAD);
    assign ld_g      = (r_state == S_GRAPH);
    assign compare   = (r_state == S_GUESS);
    assign timecount = (r_state == S_GUESS);
    assign fill      = (r_state == S_FILL);
    assign draw      = (r_state == S_DRAW);
    assign over      = wipe && ((r_state == S_WIN) || (r_state == S_LOSE) ||
                                (r_state == S_TIMEOUT));
    assign char_idx  = r_char_idx;
    assign player    = r_player;
    assign part      = r_miss[r_player];
    assign result    = r_result;

endmodule
`default_nettype wire
